// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared types and constants for the ALU arbiter block:
//               FSM state encoding, ALU op encoding, counter width and a
//               one-hot helper for the two-requester grant index.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    // Sequencer states: wait for a request, hold operands on the ALU, return result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } alu_arb_state_t;

    // ALU operation select encoding
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Latency counter width; covers the full legal ALU_LAT range of 1..15
    localparam int CNT_W = 4;

    // Convert a grant index (0/1) into a one-hot requester vector
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant logic. A lone request is granted
//               directly; when both request, the requester that was NOT
//               granted last wins. Output is one-hot (or zero when idle).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Tie goes to the requester other than the last one served
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one add/subtract ALU between two requesters. Accepts
//               one op over valid/ready, holds the operands on the ALU for
//               ALU_LAT cycles, captures result and v/n/z flags and returns
//               them to the granted requester over a response handshake.
//               Optional feature macro: ALU_ARB_STICKY_OVF_EN adds per-
//               requester sticky overflow bits (ovf_sticky / ovf_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int ALU_LAT = 3     // legal range 1..15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][WIDTH-1:0]  req_a,
    input  logic [1:0][WIDTH-1:0]  req_b,
    input  logic [1:0]             req_op,
    output logic                   alu_en,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic                   alu_op,
    input  logic [WIDTH-1:0]       alu_res,
    input  logic                   alu_v,
    input  logic                   alu_n,
    input  logic                   alu_z,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [WIDTH-1:0]       rsp_res,
    output logic                   rsp_v,
    output logic                   rsp_n,
    output logic                   rsp_z
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    output logic [1:0]             ovf_sticky,
    input  logic [1:0]             ovf_clr
`endif
);

    // Counter preload: the count reaches zero in the ALU_LAT-th ISSUE cycle
    localparam logic [CNT_W-1:0] C_LAT_M1 = CNT_W'(ALU_LAT - 1);

    alu_arb_state_t    state_q,     state_d;
    logic              gidx_q,      gidx_d;
    logic              last_q,      last_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [WIDTH-1:0]  alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]  alu_b_q,     alu_b_d;
    logic              alu_op_q,    alu_op_d;
    logic              alu_en_q,    alu_en_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_res_q,   rsp_res_d;
    logic              rsp_v_q,     rsp_v_d;
    logic              rsp_n_q,     rsp_n_d;
    logic              rsp_z_q,     rsp_z_d;

    logic [1:0]        w_gnt;
    logic              w_rsp_hs;

    rr_arbiter2 u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (w_gnt)
    );

    // Ready only in IDLE and only to the winner; forced low while in reset
    assign req_ready = (state_q == IDLE && rst_n) ? w_gnt : 2'b00;

    // rsp_valid_q is one-hot to the owner, so the non-owner's ready is masked out
    assign w_rsp_hs = (state_q == RESP) && |(rsp_valid_q & rsp_ready);

    // Next-state and datapath register updates for the sequencer
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_en_d    = alu_en_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_v_d     = rsp_v_q;
        rsp_n_d     = rsp_n_q;
        rsp_z_d     = rsp_z_q;

        case (state_q)
            IDLE: begin
                if (|w_gnt) begin
                    gidx_d   = w_gnt[1];
                    alu_a_d  = req_a[w_gnt[1]];
                    alu_b_d  = req_b[w_gnt[1]];
                    alu_op_d = req_op[w_gnt[1]];
                    cnt_d    = C_LAT_M1;
                    alu_en_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    rsp_res_d   = alu_res;
                    rsp_v_d     = alu_v;
                    rsp_n_d     = alu_n;
                    rsp_z_d     = alu_z;
                    rsp_valid_d = onehot2(gidx_q);
                    alu_en_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (w_rsp_hs) begin
                    rsp_valid_d = 2'b00;
                    last_d      = gidx_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gidx_q      <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_OP_ADD;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_res_q   <= '0;
            rsp_v_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_en_q    <= alu_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_v_q     <= rsp_v_d;
            rsp_n_q     <= rsp_n_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    assign alu_en    = alu_en_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_z     = rsp_z_q;

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] ovf_sticky_q, ovf_sticky_d;

    // Overflow seen on a completed response sets the owner's bit; set beats clear
    always_comb begin
        ovf_sticky_d = ovf_sticky_q & ~ovf_clr;
        if (w_rsp_hs && rsp_v_q) begin
            ovf_sticky_d = ovf_sticky_d | onehot2(gidx_q);
        end
    end

    // Sticky overflow storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 2'b00;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter. Includes a behavioural 6-bit
//               add/sub ALU that only presents the true result after ALU_LAT
//               enabled cycles (garbage before that). Sticky overflow checks
//               are compiled when ALU_ARB_STICKY_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W   = 6;
    localparam int LAT = 3;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][W-1:0]   req_a;
    logic [1:0][W-1:0]   req_b;
    logic [1:0]          req_op;
    logic                alu_en;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic                alu_op;
    logic [W-1:0]        alu_res;
    logic                alu_v;
    logic                alu_n;
    logic                alu_z;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [W-1:0]        rsp_res;
    logic                rsp_v;
    logic                rsp_n;
    logic                rsp_z;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0]          ovf_sticky;
    logic [1:0]          ovf_clr;
`endif

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_en    (alu_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .alu_v     (alu_v),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_v     (rsp_v),
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z)
`ifdef ALU_ARB_STICKY_OVF_EN
        ,
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: count enabled cycles, expose the real result only once settled
    int en_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else        en_cnt <= alu_en ? en_cnt + 1 : 0;
    end

    logic [W-1:0] m_r;
    logic         m_v;
    always_comb begin
        m_r = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
        if (alu_op) m_v = (alu_a[W-1] != alu_b[W-1]) && (m_r[W-1] != alu_a[W-1]);
        else        m_v = (alu_a[W-1] == alu_b[W-1]) && (m_r[W-1] != alu_a[W-1]);
        if (alu_en && en_cnt >= LAT - 1) begin
            alu_res = m_r;
            alu_v   = m_v;
            alu_n   = m_r[W-1];
            alu_z   = (m_r == '0);
        end else begin
            alu_res = ~m_r;
            alu_v   = ~m_v;
            alu_n   = ~m_r[W-1];
            alu_z   = (m_r != '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        n_total++;
        if ({alu_en, rsp_valid, req_ready, alu_a, alu_b, alu_op, rsp_res, rsp_v, rsp_n, rsp_z} !== '0) begin
            $display("FAIL reset_outputs: en=%b rv=%b rr=%b a=%h b=%h op=%b res=%h vnz=%b%b%b expected all 0",
                     alu_en, rsp_valid, req_ready, alu_a, alu_b, alu_op, rsp_res, rsp_v, rsp_n, rsp_z);
        end else n_pass++;
`ifdef ALU_ARB_STICKY_OVF_EN
        n_total++;
        if (ovf_sticky !== 2'b00) $display("FAIL reset_sticky: got %b expected 00", ovf_sticky);
        else n_pass++;
`endif
    endtask

    // One op from a single requester with rsp_ready already high
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] er, input logic ev,
                          input logic en, input logic ez, input string nm);
        logic [1:0] oh;
        int  cyc;
        bit  got;
        bit  en_ok;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        rsp_ready      = 2'b11;
        req_valid      = oh;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_op[idx]    = op;
        @(negedge clk);
        n_total++;
        if (req_ready !== oh) $display("FAIL %s_ready: got %b expected %b", nm, req_ready, oh);
        else n_pass++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        cyc = 0; got = 0; en_ok = 1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== 2'b00) got = 1;
            else if (alu_en !== 1'b1) en_ok = 0;
        end
        n_total++;
        if (!got || cyc != LAT + 1 || !en_ok)
            $display("FAIL %s_latency: rsp_valid in cycle %0d (seen=%0d, en_ok=%0d) expected cycle %0d with alu_en high before",
                     nm, cyc, got, en_ok, LAT + 1);
        else n_pass++;
        n_total++;
        if (rsp_valid !== oh || rsp_res !== er || {rsp_v, rsp_n, rsp_z} !== {ev, en, ez})
            $display("FAIL %s_result: rv=%b res=%h vnz=%b%b%b expected rv=%b res=%h vnz=%b%b%b",
                     nm, rsp_valid, rsp_res, rsp_v, rsp_n, rsp_z, oh, er, ev, en, ez);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b00 || alu_en !== 1'b0)
            $display("FAIL %s_done: rv=%b en=%b expected 00/0", nm, rsp_valid, alu_en);
        else n_pass++;
    endtask

    task automatic test_ops();
        run_op(0, 6'd5,  6'd5,  1'b0, 6'd10,  1'b0, 1'b0, 1'b0, "add_5_5");
        run_op(1, 6'd25, 6'd15, 1'b0, 6'h28,  1'b1, 1'b1, 1'b0, "add_25_15");
`ifdef ALU_ARB_STICKY_OVF_EN
        n_total++;
        if (ovf_sticky !== 2'b10) $display("FAIL sticky_set: got %b expected 10", ovf_sticky);
        else n_pass++;
`endif
        run_op(1, 6'd5,  6'd15, 1'b1, 6'h36,  1'b0, 1'b1, 1'b0, "sub_5_15");
        run_op(0, 6'd5,  6'd5,  1'b1, 6'h00,  1'b0, 1'b0, 1'b1, "sub_5_5");
    endtask

`ifdef ALU_ARB_STICKY_OVF_EN
    task automatic test_sticky();
        @(posedge clk); #1;
        ovf_clr = 2'b10;
        @(posedge clk); #1;
        ovf_clr = 2'b00;
        n_total++;
        if (ovf_sticky !== 2'b00) $display("FAIL sticky_clear: got %b expected 00", ovf_sticky);
        else n_pass++;
        // Clear held through the whole op, so it coincides with the setting handshake
        ovf_clr = 2'b10;
        run_op(1, 6'd25, 6'd15, 1'b0, 6'h28, 1'b1, 1'b1, 1'b0, "sticky_op");
        n_total++;
        if (ovf_sticky !== 2'b10) $display("FAIL sticky_set_wins: got %b expected 10", ovf_sticky);
        else n_pass++;
        ovf_clr = 2'b00;
    endtask
`endif

    task automatic test_backpressure();
        int  cyc;
        bit  got;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_a[0] = 6'd7; req_b[0] = 6'd8; req_op[0] = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_a[1] = 6'd1; req_b[1] = 6'd1; req_op[1] = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== 2'b00) got = 1;
        end
        n_total++;
        if (!got || cyc != LAT + 1) $display("FAIL bp_latency: cycle %0d seen=%0d expected %0d", cyc, got, LAT + 1);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (rsp_valid !== 2'b01 || rsp_res !== 6'd15 || req_ready !== 2'b00 || alu_en !== 1'b0)
                $display("FAIL bp_hold[%0d]: rv=%b res=%h rr=%b en=%b expected 01/0f/00/0",
                         i, rsp_valid, rsp_res, req_ready, alu_en);
            else n_pass++;
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b01) $display("FAIL bp_non_owner: rv=%b expected 01", rsp_valid);
        else n_pass++;
        rsp_ready = 2'b01;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10)
            $display("FAIL bp_release: rv=%b rr=%b expected 00/10", rsp_valid, req_ready);
        else n_pass++;
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (alu_en !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00)
                $display("FAIL withdraw[%0d]: en=%b rr=%b rv=%b expected 0/00/00", i, alu_en, req_ready, rsp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_a[0] = 6'd3; req_b[0] = 6'd4; req_op[0] = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_total++;
        if (alu_en !== 1'b1 || alu_a !== 6'd3 || alu_b !== 6'd4)
            $display("FAIL mid_issue: en=%b a=%h b=%h expected 1/03/04", alu_en, alu_a, alu_b);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]   exp_g;
        logic [W-1:0] exp_r;
        int  cyc;
        bit  got;
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        req_a[0] = 6'd1;  req_b[0] = 6'd2; req_op[0] = 1'b0;
        req_a[1] = 6'd10; req_b[1] = 6'd3; req_op[1] = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (i % 2 == 0) ? 6'd3  : 6'd7;
            cyc = 0; got = 0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (req_ready !== 2'b00) got = 1;
            end
            n_total++;
            if (!got || req_ready !== exp_g) $display("FAIL b2b_grant[%0d]: got %b expected %b", i, req_ready, exp_g);
            else n_pass++;
            cyc = 0; got = 0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (rsp_valid !== 2'b00) got = 1;
            end
            n_total++;
            if (!got || rsp_valid !== exp_g || rsp_res !== exp_r)
                $display("FAIL b2b_rsp[%0d]: rv=%b res=%h expected %b/%h", i, rsp_valid, rsp_res, exp_g, exp_r);
            else n_pass++;
        end
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (alu_en !== 1'b0 || req_ready !== 2'b00)
            $display("FAIL b2b_idle: en=%b rr=%b expected 0/00", alu_en, req_ready);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = 2'b00;
        rsp_ready = 2'b00;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clr   = 2'b00;
`endif
        #2;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_ops();
`ifdef ALU_ARB_STICKY_OVF_EN
        test_sticky();
`endif
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
